bin_to_bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It is the successor to the fixed 16-bit combinational converter that drives the 7-segment digit outputs. It adds arbitrary input width and digit count, a start/busy/done handshake, a held output register and a display-enable blanking input. It sits between the hash/time datapath and the digit drivers.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bin_to_bcd_seq.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   BLANK_CODE : nibble shown for a blanked digit
//   state_e    : converter FSM states
//   min_digits : smallest digit count that can hold any WIDTH-bit value
package bcd_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    StIdle,
    StConv
  } state_e;

  // ceil(width * log10(2)), with log10(2) approximated as 0.30103.
  function automatic int unsigned min_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   digit_i : BCD nibble before correction (0..9)
//   digit_o : corrected nibble
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // A nibble <= 9 plus 3 is at most 12, so no carry out is possible.
  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
//   sysclk  : clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : conversion request, sampled only when idle
//   bin_in  : WIDTH-bit unsigned value, captured on the accepting edge
//   enable  : display enable; low shows BLANK_CODE on every digit
//   bcd_out : DIGITS BCD digits, digit 0 in bits [3:0]
//   busy    : conversion in progress
//   done    : one-cycle pulse when bcd_out takes a new result
//   valid   : sticky, set after the first completed conversion
// Optional feature macro BIN_TO_BCD_LZB_EN: blank leading zero digits (digit 0 always shown).
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  valid
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (WIDTH < 1) begin : g_width_err
    $fatal(1, "bin_to_bcd_seq: WIDTH must be at least 1");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_digits_err
    $fatal(1, "bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SrW-1:0]    sr_q, sr_d;
  logic [BcdW-1:0]   res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;

  logic [BcdW-1:0]   adj_field;
  logic [SrW-1:0]    sr_step;

  // Correct every BCD digit of the shift register in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (sr_q[WIDTH + 4*g +: 4]),
      .digit_o (adj_field[4*g +: 4])
    );
  end

  assign sr_step = {adj_field, sr_q[WIDTH-1:0]} << 1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d    = {{BcdW{1'b0}}, bin_in};
          cnt_d   = CntW'(WIDTH);
          busy_d  = 1'b1;
          state_d = StConv;
        end
      end
      StConv: begin
        sr_d  = sr_step;
        cnt_d = cnt_q - CntW'(1);
        // Last iteration: publish the BCD field directly from the shifted value.
        if (cnt_q == CntW'(1)) begin
          res_d   = sr_step[SrW-1 -: BcdW];
          done_d  = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_q    <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Display masking is purely combinational on the held result.
  always_comb begin
`ifdef BIN_TO_BCD_LZB_EN
    logic lead;
`endif
    bcd_out = enable ? res_q : {DIGITS{BLANK_CODE}};
`ifdef BIN_TO_BCD_LZB_EN
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (bcd_out[4*i +: 4] == 4'h0)) begin
        bcd_out[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
`endif
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [15:0] val;
    logic [19:0] exp;
  } vec_t;

  logic        sysclk = 1'b0;
  logic        rst    = 1'b1;
  logic        start  = 1'b0;
  logic [15:0] bin_in = '0;
  logic        enable = 1'b1;
  logic [19:0] bcd_out;
  logic        busy, done, valid;

  logic        start8 = 1'b0;
  logic [7:0]  bin8   = '0;
  logic [11:0] bcd8;
  logic        busy8, done8, valid8;

  int total = 0;
  int bad   = 0;
  logic [19:0] sb[$];
  logic [19:0] prev;

  always #5 sysclk = ~sysclk;

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut (
    .sysclk  (sysclk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .enable  (enable),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done),
    .valid   (valid)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .sysclk  (sysclk),
    .rst     (rst),
    .start   (start8),
    .bin_in  (bin8),
    .enable  (1'b1),
    .bcd_out (bcd8),
    .busy    (busy8),
    .done    (done8),
    .valid   (valid8)
  );

  // Expected display of a 5-digit result, including optional leading-zero blanking.
  function automatic logic [19:0] shown(input logic [19:0] v);
    logic [19:0] r;
    r = v;
`ifdef BIN_TO_BCD_LZB_EN
    for (int i = 4; i >= 1; i--) begin
      if (r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
      else break;
    end
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      check(name, 32'(bcd_out), 32'(sb.pop_front()));
    end
  endtask

  // One full conversion; bin_in is scrambled during CONV and the old result must hold.
  task automatic do_conv(input logic [15:0] v, input logic [19:0] exp);
    int cyc;
    int n;
    @(negedge sysclk);
    start  = 1'b1;
    bin_in = v;
    sb.push_back(shown(exp));
    @(negedge sysclk);
    start  = 1'b0;
    bin_in = 16'($urandom);
    cyc = 0;
    n   = 0;
    while (!done && n < 40) begin
      if (busy) cyc++;
      check("hold", 32'(bcd_out), 32'(prev));
      n++;
      @(negedge sysclk);
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      pop_check("result");
      check("busy_len", 32'(cyc), 32'd16);
      check("busy_at_done", 32'(busy), 32'd0);
      check("valid", 32'(valid), 32'd1);
      prev = shown(exp);
      @(negedge sysclk);
      check("done_pulse", 32'(done), 32'd0);
    end
  endtask

  initial begin
    vec_t tab[8];
    vec_t cont[3];
    int   cyc;
    int   n;
    logic seen;

    tab[0] = '{16'd65535, 20'h65535};
    tab[1] = '{16'd0,     20'h00000};
    tab[2] = '{16'd10000, 20'h10000};
    tab[3] = '{16'd12345, 20'h12345};
    tab[4] = '{16'd42,    20'h00042};
    tab[5] = '{16'd9999,  20'h09999};
    tab[6] = '{16'd1,     20'h00001};
    tab[7] = '{16'd59999, 20'h59999};
    cont[0] = '{16'd4321,  20'h04321};
    cont[1] = '{16'd60000, 20'h60000};
    cont[2] = '{16'd777,   20'h00777};

    // Reset state
    #12;
    check("rst_bcd", 32'(bcd_out), 32'(shown(20'h0)));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_bcd8", 32'(bcd8), 32'h000);
    @(negedge sysclk);
    rst  = 1'b0;
    prev = shown(20'h0);

    for (int i = 0; i < 8; i++) do_conv(tab[i].val, tab[i].exp);

    // start held high: accepts at c = 0, 17, 34; done at c = 17, 34, 51.
    for (int c = 0; c <= 51; c++) begin
      @(negedge sysclk);
      check("cont_done", 32'(done), 32'((c > 0) && (c % 17 == 0)));
      if (done) pop_check("cont_result");
      if (c % 17 == 0 && c / 17 < 3) begin
        start  = 1'b1;
        bin_in = cont[c / 17].val;
        sb.push_back(shown(cont[c / 17].exp));
      end else if (c / 17 < 3) begin
        start  = 1'b1;
        bin_in = 16'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    prev  = shown(cont[2].exp);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    @(negedge sysclk);
    start  = 1'b1;
    bin_in = 16'd5555;
    @(negedge sysclk);
    start = 1'b0;
    repeat (7) @(negedge sysclk);
    #2 rst = 1'b1;
    #1;
    check("arst_bcd", 32'(bcd_out), 32'(shown(20'h0)));
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    @(negedge sysclk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge sysclk);
      if (done) seen = 1'b1;
    end
    check("arst_no_done", 32'(seen), 32'd0);
    prev = shown(20'h0);
    do_conv(16'd1234, 20'h01234);

    // Display enable masking.
    do_conv(16'd12345, 20'h12345);
    @(negedge sysclk);
    enable = 1'b0;
    #1 check("blank_12345", 32'(bcd_out), 32'hFFFFF);
    enable = 1'b1;
    #1 check("show_12345", 32'(bcd_out), 32'(shown(20'h12345)));
    do_conv(16'd42, 20'h00042);
    enable = 1'b0;
    #1 check("blank_42", 32'(bcd_out), 32'hFFFFF);
    enable = 1'b1;
    #1 check("show_42", 32'(bcd_out), 32'(shown(20'h00042)));

    // WIDTH=8, DIGITS=3 instance.
    @(negedge sysclk);
    start8 = 1'b1;
    bin8   = 8'd255;
    @(negedge sysclk);
    start8 = 1'b0;
    bin8   = 8'd3;
    cyc = 0;
    n   = 0;
    while (!done8 && n < 30) begin
      if (busy8) cyc++;
      n++;
      @(negedge sysclk);
    end
    check("w8_done_seen", 32'(done8), 32'd1);
    check("w8_result", 32'(bcd8), 32'h255);
    check("w8_busy_len", 32'(cyc), 32'd8);
    check("w8_valid", 32'(valid8), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
